alu_arbiter: RTL and testbench

- Round-robin scheduler that shares one ALU instance (32-bit src_1/src_2 in, 33-bit result out, sum plus carry) among NUM_REQ requesters.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Operands are held stable at the ALU for ALU_LATENCY cycles, then the result is registered and returned to the granted requester.
- Sits between ALU clients (decode/issue stubs, testbench drivers) and the single ALU instance.

---
 rtl/alu_arbiter_if.sv | 22 ++
 rtl/alu_arbiter.sv | 124 ++++++++++++
 tb/tb_alu_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response channel bundle between ALU clients and alu_arbiter
interface alu_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_src_1;
  logic [32*NUM_REQ-1:0] req_src_2;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic [32:0]           rsp_result;

  modport master (
    output req_valid, req_src_1, req_src_2, rsp_ready,
    input  req_ready, rsp_valid, rsp_result
  );

  modport slave (
    input  req_valid, req_src_1, req_src_2, rsp_ready,
    output req_ready, rsp_valid, rsp_result
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU among NUM_REQ requesters
// Optional completed-operation counter enabled by macro ALU_ARBITER_OP_COUNT_EN.
module alu_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ALU_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  alu_arbiter_if.slave bus,
  output logic [31:0] alu_src_1,
  output logic [31:0] alu_src_2,
  input  logic [32:0] alu_result,
  output logic        busy,
  output logic [15:0] op_count
);
  localparam int GW = (NUM_REQ < 2) ? 1 : $clog2(NUM_REQ);
  localparam int CW = (ALU_LATENCY < 2) ? 1 : $clog2(ALU_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state, state_next;
  logic [GW-1:0]       last_grant;
  logic [GW-1:0]       grant;
  logic [CW-1:0]       cnt;
  logic [31:0]         op_1, op_2;
  logic [32:0]         result_q;
  logic [GW-1:0]       win_idx;
  logic [GW-1:0]       scan_idx;
  logic                win_found;
  logic [NUM_REQ-1:0]  ready_vec;
  logic [NUM_REQ-1:0]  valid_vec;
  logic                accept;
  logic                rsp_fire;

  // Scan upward from the requester after the last one served, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = GW'((int'(last_grant) + k) % NUM_REQ);
      if (!win_found && bus.req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_next = state;
    ready_vec  = '0;
    valid_vec  = '0;
    accept     = 1'b0;
    rsp_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          ready_vec[win_idx] = 1'b1;
          accept             = 1'b1;
          state_next         = EXEC;
        end
      end
      EXEC: begin
        if (cnt == CW'(1)) state_next = RESP;
      end
      RESP: begin
        valid_vec[grant] = 1'b1;
        if (bus.rsp_ready[grant]) begin
          rsp_fire   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GW'(NUM_REQ - 1);
      grant      <= '0;
      cnt        <= '0;
      op_1       <= '0;
      op_2       <= '0;
      result_q   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_1  <= bus.req_src_1[32*win_idx +: 32];
        op_2  <= bus.req_src_2[32*win_idx +: 32];
        grant <= win_idx;
        cnt   <= CW'(ALU_LATENCY);
      end
      if (state == EXEC) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) result_q <= alu_result;
      end
      if (rsp_fire) last_grant <= grant;
    end
  end

`ifdef ALU_ARBITER_OP_COUNT_EN
  logic [15:0] op_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_q <= '0;
    end else if (rsp_fire && op_count_q != 16'hFFFF) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count = op_count_q;
`else
  assign op_count = 16'h0000;
`endif

  assign bus.req_ready  = ready_vec;
  assign bus.rsp_valid  = valid_vec;
  assign bus.rsp_result = result_q;
  assign alu_src_1      = op_1;
  assign alu_src_2      = op_2;
  assign busy           = (state != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter (latency 1 and latency 3 instances)
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arbiter_if #(.NUM_REQ(4)) bus1();
  alu_arbiter_if #(.NUM_REQ(4)) bus3();

  logic [31:0] a1_src_1, a1_src_2, a3_src_1, a3_src_2;
  logic [32:0] a1_result, a3_result;
  logic        busy1, busy3;
  logic [15:0] ops1, ops3;
  logic        poison;

  assign a1_result = {1'b0, a1_src_1} + {1'b0, a1_src_2};
  assign a3_result = poison ? 33'h1_DEAD_BEEF : ({1'b0, a3_src_1} + {1'b0, a3_src_2});

  alu_arbiter #(.NUM_REQ(4), .ALU_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .alu_src_1(a1_src_1), .alu_src_2(a1_src_2), .alu_result(a1_result),
    .busy(busy1), .op_count(ops1)
  );

  alu_arbiter #(.NUM_REQ(4), .ALU_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3),
    .alu_src_1(a3_src_1), .alu_src_2(a3_src_2), .alu_result(a3_result),
    .busy(busy3), .op_count(ops3)
  );

  typedef struct {
    int          idx;
    logic [32:0] res;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total = 0;
  int   cyc = 0;
  int   hs_count = 0;
  int   last_rsp_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [32:0] sum33(input logic [31:0] a, input logic [31:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic [63:0] exp_ops();
`ifdef ALU_ARBITER_OP_COUNT_EN
    return 64'(hs_count);
`else
    return 64'd0;
`endif
  endfunction

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    bus1.req_src_1[32*i +: 32] = a;
    bus1.req_src_2[32*i +: 32] = b;
  endtask

  task automatic drive(input int i, input logic [31:0] a, input logic [31:0] b);
    set_op(i, a, b);
    bus1.req_valid[i] = 1'b1;
    sb.push_back('{i, sum33(a, b)});
  endtask

  task automatic wait_rsp(input string tag);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus1.rsp_valid == '0 && n < 20);
    if (bus1.rsp_valid == '0) begin
      check({tag, " rsp_seen"}, 64'(bus1.rsp_valid != '0), 64'(1));
      return;
    end
    if (sb.size() == 0) begin
      check({tag, " unexpected"}, 64'(bus1.rsp_valid), 64'(0));
      return;
    end
    e = sb.pop_front();
    check({tag, " valid"}, 64'(bus1.rsp_valid), 64'(1) << e.idx);
    check({tag, " result"}, 64'(bus1.rsp_result), 64'(e.res));
    last_rsp_cyc = cyc;
    hs_count++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus1.req_valid = '0; bus1.req_src_1 = '0; bus1.req_src_2 = '0; bus1.rsp_ready = '0;
    bus3.req_valid = '0; bus3.req_src_1 = '0; bus3.req_src_2 = '0; bus3.rsp_ready = '0;
    poison = 1'b0;
    sb.delete();
    hs_count = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc_e;
    int prev;
    do_reset();
    rst = 1'b1;
    #1;
    check("rst req_ready", 64'(bus1.req_ready), 64'(0));
    check("rst rsp_valid", 64'(bus1.rsp_valid), 64'(0));
    check("rst rsp_result", 64'(bus1.rsp_result), 64'(0));
    check("rst alu_src", 64'({a1_src_1, a1_src_2}), 64'(0));
    check("rst busy", 64'({busy1, busy3}), 64'(0));
    check("rst op_count", 64'({ops1, ops3}), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // single request on requester 0
    bus1.rsp_ready = 4'hF;
    set_op(0, 32'h0000_0005, 32'h0000_0003);
    bus1.req_valid = 4'b0001;
    sb.push_back('{0, 33'h0_0000_0008});
    #1;
    check("single req_ready", 64'(bus1.req_ready), 64'(4'b0001));
    check("single idle busy", 64'(busy1), 64'(0));
    @(posedge clk);
    #1;
    cyc_e = cyc;
    bus1.req_valid = '0;
    check("single exec busy", 64'(busy1), 64'(1));
    check("single exec req_ready", 64'(bus1.req_ready), 64'(0));
    check("single alu_src_1", 64'(a1_src_1), 64'(32'h5));
    wait_rsp("single");
    check("single latency", 64'(last_rsp_cyc - cyc_e), 64'(1));
    @(negedge clk);
    check("single done busy", 64'(busy1), 64'(0));
    check("single op_count", 64'(ops1), exp_ops());

    // carry out on requester 2
    set_op(2, 32'hFFFF_FFFF, 32'h0000_0001);
    bus1.req_valid = 4'b0100;
    sb.push_back('{2, 33'h1_0000_0000});
    @(posedge clk);
    #1;
    bus1.req_valid = '0;
    wait_rsp("carry");
    @(negedge clk);

    // back-pressure on requester 1 while requester 0 waits
    bus1.rsp_ready = 4'b1101;
    drive(1, 32'h1234_5678, 32'h1111_1111);
    @(posedge clk);
    #1;
    bus1.req_valid = '0;
    wait_rsp("bp");
    drive(0, 32'h0000_00AA, 32'h0000_0055);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp hold valid", 64'(bus1.rsp_valid), 64'(4'b0010));
      check("bp hold result", 64'(bus1.rsp_result), 64'(33'h0_2345_6789));
      check("bp hold req_ready", 64'(bus1.req_ready), 64'(0));
      check("bp hold alu_src_1", 64'(a1_src_1), 64'(32'h1234_5678));
    end
    bus1.rsp_ready = 4'hF;
    @(negedge clk);
    check("bp release busy", 64'(busy1), 64'(0));
    check("bp release req_ready", 64'(bus1.req_ready), 64'(4'b0001));
    @(posedge clk);
    #1;
    bus1.req_valid = '0;
    wait_rsp("bp next");
    @(negedge clk);
    check("bp op_count", 64'(ops1), exp_ops());

    // round robin with all requesters active
    do_reset();
    bus1.rsp_ready = 4'hF;
    for (int i = 0; i < 4; i++) set_op(i, 32'h1000_0000 * (i + 1) + i, 32'h0F00_0000 + 3 * i);
    set_op(3, 32'hF000_0000, 32'h2000_0001);
    for (int i = 0; i < 4; i++)
      sb.push_back('{i, sum33(bus1.req_src_1[32*i +: 32], bus1.req_src_2[32*i +: 32])});
    sb.push_back('{0, sum33(bus1.req_src_1[31:0], bus1.req_src_2[31:0])});
    bus1.req_valid = 4'hF;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_rsp("rr");
      if (k > 0) check("rr interval", 64'(last_rsp_cyc - prev), 64'(3));
      prev = last_rsp_cyc;
      if (k == 4) bus1.req_valid = '0;
    end
    @(negedge clk);
    check("rr op_count", 64'(ops1), exp_ops());

    // reset during EXEC abandons the operation
    set_op(3, 32'h0000_0100, 32'h0000_0200);
    bus1.req_valid = 4'b1000;
    @(posedge clk);
    @(negedge clk);
    check("mid busy", 64'(busy1), 64'(1));
    rst = 1'b1;
    bus1.req_valid = '0;
    #1;
    check("mid rst rsp_valid", 64'(bus1.rsp_valid), 64'(0));
    check("mid rst busy", 64'(busy1), 64'(0));
    check("mid rst alu_src", 64'({a1_src_1, a1_src_2}), 64'(0));
    check("mid rst op_count", 64'(ops1), 64'(0));
    @(negedge clk);
    check("mid rst no rsp", 64'(bus1.rsp_valid), 64'(0));
    rst = 1'b0;
    hs_count = 0;
    set_op(0, 32'h0000_0007, 32'h0000_0009);
    bus1.req_valid = 4'b1001;
    sb.push_back('{0, 33'h0_0000_0010});
    #1;
    check("mid tie req_ready", 64'(bus1.req_ready), 64'(4'b0001));
    @(posedge clk);
    #1;
    bus1.req_valid = '0;
    wait_rsp("mid after");
    @(negedge clk);

    // latency 3 instance; poisoned ALU output before the capture edge
    bus3.rsp_ready = 4'hF;
    bus3.req_src_1[31:0] = 32'd10;
    bus3.req_src_2[31:0] = 32'd20;
    bus3.req_valid = 4'b0001;
    poison = 1'b1;
    @(posedge clk);
    #1;
    bus3.req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lat3 no rsp", 64'(bus3.rsp_valid), 64'(0));
      check("lat3 alu_src", 64'({a3_src_1, a3_src_2}), {32'd10, 32'd20});
      if (i == 2) poison = 1'b0;
    end
    @(negedge clk);
    check("lat3 valid", 64'(bus3.rsp_valid), 64'(4'b0001));
    check("lat3 result", 64'(bus3.rsp_result), 64'(33'd30));
    @(negedge clk);
    check("lat3 done busy", 64'(busy3), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
